// File: rtl/xbar_snoop_arbiter.sv
// rtl/xbar_snoop_arbiter.sv - round-robin snoop broadcast arbiter and response sequencer for the coherence crossbar
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req, req_msg                     per-CPU snoop request and message (message valid while req high)
//   xbar_in                          per-CPU crossbar inputs; only the granted slot carries the message
//   bcast_valid, bcast_src, grant    broadcast in progress, granted CPU index, one-hot grant
//   snoop_ack/shared/dirty           per-CPU response pulse and its line-state flags
//   done, done_shared, done_dirty    completion pulse to the winner with aggregated flags
module xbar_snoop_arbiter #(
  parameter  int NUM_CPUS = 4,
  parameter  int MSG_W    = 32,
  localparam int SRC_W    = $clog2(NUM_CPUS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CPUS-1:0]                req,
  input  logic [NUM_CPUS-1:0][MSG_W-1:0]     req_msg,
  output logic [NUM_CPUS-1:0][MSG_W-1:0]     xbar_in,
  output logic                               bcast_valid,
  output logic [SRC_W-1:0]                   bcast_src,
  output logic [NUM_CPUS-1:0]                grant,
  input  logic [NUM_CPUS-1:0]                snoop_ack,
  input  logic [NUM_CPUS-1:0]                snoop_shared,
  input  logic [NUM_CPUS-1:0]                snoop_dirty,
  output logic [NUM_CPUS-1:0]                done,
  output logic                               done_shared,
  output logic                               done_dirty
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BCAST = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [NUM_CPUS-1:0] ack_mask_q, ack_mask_d;
  logic                shared_q, shared_d;
  logic                dirty_q, dirty_d;

  logic                found;
  logic [SRC_W-1:0]    winner;
  logic [SRC_W-1:0]    winner_nxt;
  logic [NUM_CPUS-1:0] src_onehot;
  logic [NUM_CPUS-1:0] others;
  logic [NUM_CPUS-1:0] acks_new;
  logic [NUM_CPUS-1:0] mask_next;
  logic                complete;

  // First requester at or above rr_ptr, wrapping past NUM_CPUS-1 to 0.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CPUS) idx = idx - NUM_CPUS;
      cand = SRC_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign winner_nxt = (int'(winner) == NUM_CPUS - 1) ? '0 : winner + SRC_W'(1);

  assign src_onehot = NUM_CPUS'(1) << src_q;
  assign others     = ~src_onehot;
  // Only first acks from non-source CPUs count; repeats and the source's own ack are dropped
  // so their flags never reach the sticky OR.
  assign acks_new   = snoop_ack & others & ~ack_mask_q;
  assign mask_next  = ack_mask_q | acks_new;
  assign complete   = (mask_next == others);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    msg_d      = msg_q;
    ack_mask_d = ack_mask_q;
    shared_d   = shared_q;
    dirty_d    = dirty_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          msg_d    = req_msg[winner];
          src_d    = winner;
          rr_ptr_d = winner_nxt;
          state_d  = BCAST;
        end
      end
      BCAST: begin
        ack_mask_d = mask_next;
        shared_d   = shared_q | (|(acks_new & snoop_shared));
        dirty_d    = dirty_q  | (|(acks_new & snoop_dirty));
        if (complete) state_d = DONE;
      end
      DONE: begin
        ack_mask_d = '0;
        shared_d   = 1'b0;
        dirty_d    = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      src_q      <= '0;
      msg_q      <= '0;
      ack_mask_q <= '0;
      shared_q   <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      msg_q      <= msg_d;
      ack_mask_q <= ack_mask_d;
      shared_q   <= shared_d;
      dirty_q    <= dirty_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them without waiting for a clock.
  assign bcast_valid = (state_q == BCAST);
  assign bcast_src   = src_q;
  assign grant       = bcast_valid ? src_onehot : '0;
  assign done        = (state_q == DONE) ? src_onehot : '0;
  assign done_shared = (state_q == DONE) & shared_q;
  assign done_dirty  = (state_q == DONE) & dirty_q;

  always_comb begin
    xbar_in = '0;
    if (bcast_valid) xbar_in[src_q] = msg_q;
  end

endmodule

// File: doc/xbar_snoop_arbiter.md
Name: xbar_snoop_arbiter

Overview:
Round-robin arbiter and sequencer for the coherence crossbar. It grants one CPU's snoop message at a time and latches that message. It drives the message as the single broadcast source into the crossbar's per-CPU inputs, then collects snoop acks/responses from every other CPU. When all responses are in, it returns an aggregated result to the winning requester and releases the crossbar.

Parameters:
NUM_CPUS, 4, number of cache controllers sharing the crossbar (from types package, >=2)
SRC_W, $clog2(NUM_CPUS), width of source index (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  [NUM_CPUS]  per-CPU snoop request, held high until done
req_msg  in  xbar_msg_t [NUM_CPUS]  per-CPU message, valid while req high
xbar_in  out  xbar_msg_t [NUM_CPUS]  drive to crossbar inputs; only granted slot valid, others zero
bcast_valid  out  1  broadcast in progress
bcast_src  out  SRC_W  index of granted CPU
grant  out  [NUM_CPUS]  one-hot grant, zero when idle
snoop_ack  in  [NUM_CPUS]  per-CPU single-cycle ack of current broadcast
snoop_shared  in  [NUM_CPUS]  valid with ack: responder held line (S/E/M)
snoop_dirty  in  [NUM_CPUS]  valid with ack: responder held line M (supplies data)
done  out  [NUM_CPUS]  one-cycle pulse to granted CPU on completion
done_shared  out  1  OR of collected shared bits, valid with done
done_dirty  out  1  OR of collected dirty bits, valid with done

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, xbar_in all zero, ack/shared/dirty masks 0, rr pointer=0.
- FSM states: IDLE, BCAST, DONE.
- IDLE: if any req, pick first set bit searching from rr_ptr upward with wrap.
  - Next edge: latch req_msg[winner], set grant one-hot, bcast_src=winner, bcast_valid=1, state=BCAST, rr_ptr=(winner+1) mod NUM_CPUS.
  - Latency: req high at edge N gives grant/bcast_valid at N+1.
- BCAST:
  - xbar_in[bcast_src]=latched msg; all other xbar_in slots zero.
  - Each cycle, OR snoop_ack into ack_mask; for each acking CPU, OR its shared/dirty into the sticky flags.
  - Ack from bcast_src is ignored. Acks from a CPU already in ack_mask are ignored; its flags are not re-merged.
  - Complete when ack_mask covers every CPU except bcast_src, counting acks arriving this cycle. Next edge: state=DONE.
  - Minimum BCAST length is 1 cycle, when all acks arrive on the first BCAST cycle.
- DONE (exactly 1 cycle):
  - done[bcast_src]=1, done_shared/done_dirty = flags; grant, bcast_valid and xbar_in already 0.
  - Clear masks and flags; state=IDLE.
- Re-arbitration: the next grant comes no earlier than the cycle after DONE. The requester must drop req in the DONE cycle.
  - If req is still high in IDLE, it competes normally; the rr pointer gives the other requesters priority.
- Request changes: req deassertion or req_msg change during BCAST has no effect; the latched message and transaction complete.
- Simultaneous requests: rr order only, with no starvation. Worst-case wait is NUM_CPUS-1 transactions.
- Wrap: rr_ptr wraps NUM_CPUS-1 -> 0; the search wraps the same way.
- Reset mid-BCAST: immediate abort, no done pulse, all state cleared.
- done_shared/done_dirty are 0 outside DONE.
- Two dirty responders is a protocol error; done_dirty still reports 1 and no assertion is raised in RTL.

Test Plan:
- Single request: req=0100 at cycle 0, acks from CPUs 0,1,3 at cycle 3 -> grant=0100, bcast_src=2 at cycle 1; xbar_in[2]=msg, others 0; done=0100 at cycle 4; done_shared=0.
- Contention: req=1111 held, each CPU dropping req at its done -> grant order 0,1,2,3; grants to 0,1,2 are then re-requested and order repeats 0,1,2,3 with no CPU granted twice before all others.
- Staggered acks: src=1; ack CPU0 with shared=1 at cycle 2, CPU3 at cycle 4 with dirty=1, CPU2 at cycle 6 -> done at cycle 7, done_shared=1, done_dirty=1; duplicate CPU0 ack with shared=0 at cycle 5 ignored.
- Source self-ack ignored: src=0, acks only from CPU0 for 10 cycles -> no done. Then CPU1-3 ack together -> done next cycle.
- Reset mid-BCAST: assert rst during BCAST with 2 of 3 acks collected -> all outputs 0 asynchronously, no done. After release, a req=0001 is granted with rr_ptr=0 and a fresh ack mask.
- Message latch: change req_msg[2] and drop req[2] during its BCAST -> xbar_in[2] keeps the original msg until DONE.
